// File: rtl/sys_defs.sv
// Shared bus encodings, requester ids and sizing for the memory system.
// Imported by the arbiter, its tag table and the bench.
package sys_defs;

    localparam int XLEN         = 32;
    localparam int NUM_MEM_TAGS = 16;
    localparam int TAG_W        = 4;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_t;

    typedef enum logic [1:0] {
        SRC_ICACHE = 2'h0,
        SRC_DCACHE = 2'h1,
        SRC_SQ     = 2'h2
    } mem_src_t;

    typedef enum logic {
        NORMAL = 1'b0,
        BOOST  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/mem_tag_table.sv
// Per-tag owner table: who issued each outstanding load, and whether
// its return was abandoned by an icache squash.
module mem_tag_table
    import sys_defs::*;
#(
    parameter int NUM_TAGS = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             record_en,
    input  logic [TAG_W-1:0] record_tag,
    input  logic [1:0]       record_src,
    input  logic             clear_en,
    input  logic [TAG_W-1:0] clear_tag,
    input  logic             squash,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             lookup_hit,
    output logic [1:0]       lookup_src
);

    logic [NUM_TAGS-1:0] valid;
    logic [NUM_TAGS-1:0] dropped;
    logic [1:0]          src [NUM_TAGS];

    // Record beats clear (same tag reissued), clear beats squash.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid   <= '0;
            dropped <= '0;
            for (int i = 0; i < NUM_TAGS; i++) begin
                src[i] <= SRC_ICACHE;
            end
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (record_en && record_tag == TAG_W'(i)) begin
                    valid[i]   <= 1'b1;
                    dropped[i] <= 1'b0;
                    src[i]     <= record_src;
                end else if (clear_en && clear_tag == TAG_W'(i)) begin
                    valid[i]   <= 1'b0;
                    dropped[i] <= 1'b0;
                end else if (squash && valid[i] &&
                             src[i] == SRC_ICACHE) begin
                    dropped[i] <= 1'b1;
                end
            end
        end
    end

    // A live (valid, not dropped) owner for the returning tag.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_src = SRC_ICACHE;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (lookup_tag == TAG_W'(i)) begin
                lookup_hit = valid[i] && !dropped[i];
                lookup_src = src[i];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory request port between icache, dcache and the store
// queue, routes returning tags to their owner, and stops icache starving.
module mem_arbiter #(
    parameter int NUM_MEM_TAGS = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [1:0]               icache_command,
    input  logic [sys_defs::XLEN-1:0] icache_addr,
    input  logic [1:0]               dcache_command,
    input  logic [sys_defs::XLEN-1:0] dcache_addr,
    input  logic [1:0]               sq_command,
    input  logic [sys_defs::XLEN-1:0] sq_addr,
    input  logic [63:0]              sq_data,
    input  logic                     squash_icache,
    output logic [1:0]               mem_command,
    output logic [sys_defs::XLEN-1:0] mem_addr,
    output logic [63:0]              mem_data,
    input  logic [3:0]               mem_response,
    input  logic [3:0]               mem_tag,
    input  logic [63:0]              mem_rdata,
    output logic [3:0]               icache_response,
    output logic [3:0]               dcache_response,
    output logic [3:0]               sq_response,
    output logic [3:0]               icache_tag,
    output logic [3:0]               dcache_tag,
    output logic [63:0]              rdata_out
);

    import sys_defs::*;

    localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t LIMIT = cnt_t'(STARVE_LIMIT);

    arb_state_t state, state_next;
    cnt_t       starve_cnt, starve_cnt_next;

    logic       ic_req, dc_req, sq_req, any_req;
    mem_src_t   winner;
    logic       record_en;
    logic       lookup_hit;
    logic [1:0] lookup_src;

    assign ic_req    = icache_command != BUS_NONE;
    assign dc_req    = dcache_command != BUS_NONE;
    assign sq_req    = sq_command != BUS_NONE;
    assign any_req   = ic_req || dc_req || sq_req;
    assign rdata_out = mem_rdata;

    // Pick the winner; a starved icache jumps the queue while boosted.
    always_comb begin
        winner = SRC_ICACHE;
        if (state == BOOST && ic_req) begin
            winner = SRC_ICACHE;
        end else if (sq_req) begin
            winner = SRC_SQ;
        end else if (dc_req) begin
            winner = SRC_DCACHE;
        end
    end

    // Steer the winner onto the memory port and hand back its accept tag.
    always_comb begin
        mem_command     = BUS_NONE;
        mem_addr        = '0;
        mem_data        = '0;
        icache_response = '0;
        dcache_response = '0;
        sq_response     = '0;
        if (!reset && any_req) begin
            case (winner)
                SRC_SQ: begin
                    mem_command = sq_command;
                    mem_addr    = sq_addr;
                    mem_data    = sq_data;
                    sq_response = mem_response;
                end
                SRC_DCACHE: begin
                    mem_command     = dcache_command;
                    mem_addr        = dcache_addr;
                    dcache_response = mem_response;
                end
                default: begin
                    mem_command     = icache_command;
                    mem_addr        = icache_addr;
                    icache_response = mem_response;
                end
            endcase
        end
    end

    assign record_en = !reset && mem_command == BUS_LOAD &&
                       mem_response != '0;

    mem_tag_table #(
        .NUM_TAGS(NUM_MEM_TAGS)
    ) u_tag_table (
        .clock      (clock),
        .reset      (reset),
        .record_en  (record_en),
        .record_tag (mem_response),
        .record_src (winner),
        .clear_en   (mem_tag != '0),
        .clear_tag  (mem_tag),
        .squash     (squash_icache),
        .lookup_tag (mem_tag),
        .lookup_hit (lookup_hit),
        .lookup_src (lookup_src)
    );

    // Route a returning tag to whichever cache still owns it.
    always_comb begin
        icache_tag = '0;
        dcache_tag = '0;
        if (!reset && mem_tag != '0 && lookup_hit) begin
            if (lookup_src == SRC_ICACHE) begin
                icache_tag = mem_tag;
            end else if (lookup_src == SRC_DCACHE) begin
                dcache_tag = mem_tag;
            end
        end
    end

    // Starvation state and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= NORMAL;
            starve_cnt <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_cnt_next;
        end
    end

    // Count consecutive icache losses; boost once the limit is hit.
    always_comb begin
        state_next      = state;
        starve_cnt_next = starve_cnt;
        case (state)
            NORMAL: begin
                if (ic_req && winner != SRC_ICACHE) begin
                    if (starve_cnt < LIMIT) begin
                        starve_cnt_next = starve_cnt + cnt_t'(1);
                    end
                end else begin
                    starve_cnt_next = '0;
                end
                if (starve_cnt_next == LIMIT) begin
                    state_next = BOOST;
                end
            end
            default: begin
                if (!ic_req || icache_response != '0) begin
                    state_next      = NORMAL;
                    starve_cnt_next = '0;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter with a behavioural model
// of priority, tag ownership, squash and icache anti-starvation.
module tb_mem_arbiter;

    import sys_defs::*;

    localparam int L = 8;

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  ir;
        logic [3:0]  dr;
        logic [3:0]  sr;
        logic [3:0]  it;
        logic [3:0]  dt;
        logic [63:0] rd;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  icache_command, dcache_command, sq_command;
    logic [31:0] icache_addr, dcache_addr, sq_addr;
    logic [63:0] sq_data, mem_rdata;
    logic        squash_icache;
    logic [3:0]  mem_response, mem_tag;
    logic [1:0]  mem_command;
    logic [31:0] mem_addr;
    logic [63:0] mem_data, rdata_out;
    logic [3:0]  icache_response, dcache_response, sq_response;
    logic [3:0]  icache_tag, dcache_tag;

    logic        n_reset, n_squash;
    logic [1:0]  n_ic_cmd, n_dc_cmd, n_sq_cmd;
    logic [31:0] n_ic_addr, n_dc_addr, n_sq_addr;
    logic [63:0] n_sq_data, n_rdata;
    logic [3:0]  n_resp, n_tag;

    bit          ov [16];
    bit          od [16];
    int          os [16];
    int          cnt;
    bit          boost;

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;

    always #5 clock = ~clock;

    mem_arbiter #(
        .NUM_MEM_TAGS(16),
        .STARVE_LIMIT(L)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .icache_command (icache_command),
        .icache_addr    (icache_addr),
        .dcache_command (dcache_command),
        .dcache_addr    (dcache_addr),
        .sq_command     (sq_command),
        .sq_addr        (sq_addr),
        .sq_data        (sq_data),
        .squash_icache  (squash_icache),
        .mem_command    (mem_command),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_response   (mem_response),
        .mem_tag        (mem_tag),
        .mem_rdata      (mem_rdata),
        .icache_response(icache_response),
        .dcache_response(dcache_response),
        .sq_response    (sq_response),
        .icache_tag     (icache_tag),
        .dcache_tag     (dcache_tag),
        .rdata_out      (rdata_out)
    );

    task automatic idle();
        n_reset  = 1'b0;
        n_squash = 1'b0;
        n_ic_cmd = BUS_NONE;
        n_dc_cmd = BUS_NONE;
        n_sq_cmd = BUS_NONE;
        n_ic_addr = '0;
        n_dc_addr = '0;
        n_sq_addr = '0;
        n_sq_data = '0;
        n_rdata  = '0;
        n_resp   = '0;
        n_tag    = '0;
    endtask

    // Apply one cycle of stimulus and push what the model expects.
    task automatic step();
        exp_t e;
        int   w;
        int   t;
        bit   icr, dcr, sqr;
        @(posedge clock);
        #1;
        reset          = n_reset;
        squash_icache  = n_squash;
        icache_command = n_ic_cmd;
        icache_addr    = n_ic_addr;
        dcache_command = n_dc_cmd;
        dcache_addr    = n_dc_addr;
        sq_command     = n_sq_cmd;
        sq_addr        = n_sq_addr;
        sq_data        = n_sq_data;
        mem_response   = n_resp;
        mem_tag        = n_tag;
        mem_rdata      = n_rdata;
        e = '0;
        e.rd = n_rdata;
        icr = n_ic_cmd != BUS_NONE;
        dcr = n_dc_cmd != BUS_NONE;
        sqr = n_sq_cmd != BUS_NONE;
        if (n_reset) begin
            for (int i = 0; i < 16; i++) begin
                ov[i] = 1'b0;
                od[i] = 1'b0;
            end
            cnt   = 0;
            boost = 1'b0;
        end else begin
            w = -1;
            if (boost && icr) w = 0;
            else if (sqr) w = 2;
            else if (dcr) w = 1;
            else if (icr) w = 0;
            if (w == 0) begin
                e.cmd = n_ic_cmd;
                e.addr = n_ic_addr;
                e.ir = n_resp;
            end else if (w == 1) begin
                e.cmd = n_dc_cmd;
                e.addr = n_dc_addr;
                e.dr = n_resp;
            end else if (w == 2) begin
                e.cmd = n_sq_cmd;
                e.addr = n_sq_addr;
                e.data = n_sq_data;
                e.sr = n_resp;
            end
            t = int'(n_tag);
            if (t != 0 && ov[t] && !od[t]) begin
                if (os[t] == 0) e.it = n_tag;
                else if (os[t] == 1) e.dt = n_tag;
            end
            if (t != 0) begin
                ov[t] = 1'b0;
                od[t] = 1'b0;
            end
            if (n_squash) begin
                for (int i = 0; i < 16; i++) begin
                    if (ov[i] && os[i] == 0) od[i] = 1'b1;
                end
            end
            if (w >= 0 && e.cmd == BUS_LOAD && n_resp != 0) begin
                ov[n_resp] = 1'b1;
                od[n_resp] = 1'b0;
                os[n_resp] = w;
            end
            if (!boost) begin
                if (icr && w != 0) cnt = (cnt < L) ? cnt + 1 : L;
                else cnt = 0;
                if (cnt == L) boost = 1'b1;
            end else if (!icr || n_resp != 0) begin
                boost = 1'b0;
                cnt   = 0;
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compare the DUT against the oldest expectation.
    initial begin
        exp_t e, g;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                g = {mem_command, mem_addr, mem_data,
                     icache_response, dcache_response, sq_response,
                     icache_tag, dcache_tag, rdata_out};
                checks++;
                cyc++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL outputs cyc%0d got=%h exp=%h",
                             cyc, g, e);
                end
            end
        end
    end

    initial begin
        idle();
        n_reset = 1'b1;
        reset = 1'b1;
        squash_icache = 1'b0;
        icache_command = BUS_NONE;
        dcache_command = BUS_NONE;
        sq_command = BUS_NONE;
        icache_addr = '0;
        dcache_addr = '0;
        sq_addr = '0;
        sq_data = '0;
        mem_response = '0;
        mem_tag = '0;
        mem_rdata = '0;
        for (int i = 0; i < 16; i++) os[i] = 0;
        cnt = 0;
        boost = 1'b0;
        n_ic_cmd = BUS_LOAD;
        n_ic_addr = 32'h44;
        n_resp = 4'd1;
        step();
        step();

        // Store and load collide: store wins, nothing recorded.
        idle();
        n_sq_cmd = BUS_STORE;
        n_sq_addr = 32'h100;
        n_sq_data = 64'hdead_beef_0123_4567;
        n_dc_cmd = BUS_LOAD;
        n_dc_addr = 32'h200;
        n_resp = 4'd3;
        step();
        idle();
        n_tag = 4'd3;
        step();

        // Dcache load tag 5 returns four cycles later, then clears.
        idle();
        n_dc_cmd = BUS_LOAD;
        n_dc_addr = 32'h300;
        n_resp = 4'd5;
        step();
        idle();
        step();
        step();
        step();
        n_tag = 4'd5;
        n_rdata = 64'h1111_2222_3333_4444;
        step();
        step();

        // Icache starved by dcache for the limit, then boosted.
        idle();
        n_ic_cmd = BUS_LOAD;
        n_ic_addr = 32'h400;
        n_dc_cmd = BUS_LOAD;
        n_dc_addr = 32'h500;
        for (int i = 0; i < L; i++) step();
        n_resp = 4'd6;
        step();
        n_resp = 4'd0;
        step();
        step();

        // Squashed icache fetch return is suppressed.
        idle();
        n_ic_cmd = BUS_LOAD;
        n_ic_addr = 32'h600;
        n_resp = 4'd7;
        step();
        idle();
        n_squash = 1'b1;
        step();
        idle();
        n_tag = 4'd7;
        step();

        // Tag 4 returns to icache while dcache reuses tag 4.
        idle();
        n_ic_cmd = BUS_LOAD;
        n_ic_addr = 32'h700;
        n_resp = 4'd4;
        step();
        idle();
        n_dc_cmd = BUS_LOAD;
        n_dc_addr = 32'h800;
        n_resp = 4'd4;
        n_tag = 4'd4;
        step();
        idle();
        n_tag = 4'd4;
        step();

        // Reset with tags 2 and 9 outstanding drops them.
        idle();
        n_dc_cmd = BUS_LOAD;
        n_dc_addr = 32'h900;
        n_resp = 4'd2;
        step();
        idle();
        n_ic_cmd = BUS_LOAD;
        n_ic_addr = 32'ha00;
        n_resp = 4'd9;
        step();
        idle();
        n_reset = 1'b1;
        n_tag = 4'd2;
        n_dc_cmd = BUS_LOAD;
        n_resp = 4'd3;
        step();
        idle();
        n_tag = 4'd2;
        step();
        n_tag = 4'd9;
        step();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            idle();
            n_reset = ($urandom_range(0, 99) == 0);
            n_squash = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) < 7) n_ic_cmd = BUS_LOAD;
            if ($urandom_range(0, 9) < 6) n_dc_cmd = BUS_LOAD;
            if ($urandom_range(0, 9) < 3) n_sq_cmd = BUS_STORE;
            n_ic_addr = $urandom;
            n_dc_addr = $urandom;
            n_sq_addr = $urandom;
            n_sq_data = {$urandom, $urandom};
            n_rdata = {$urandom, $urandom};
            if ($urandom_range(0, 9) >= 3) n_resp = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) n_tag = 4'($urandom_range(1, 15));
            step();
        end

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clock);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
